// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues req/ack data-memory accesses, stalls the upstream
// pipeline while one is outstanding, and fills the MEM/WB register with extended load data.
module mem_stage_lsu #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int WORD_BITWIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_memRead,
    input  logic                        mem_memWrite,
    input  logic                        mem_memToReg,
    input  logic                        mem_regWrite,
    input  logic [REG_NUM_BITWIDTH-1:0] mem_regToWrite,
    input  logic [WORD_BITWIDTH-1:0]    mem_ALUresult,
    input  logic [WORD_BITWIDTH-1:0]    mem_finalReadData2,
    input  logic [2:0]                  mem_funct3,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [WORD_BITWIDTH-1:0]    dmem_addr,
    output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
    output logic [3:0]                  dmem_be,
    input  logic                        dmem_ack,
    input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
    output logic                        stall,
    output logic                        wb_regWrite,
    output logic                        wb_memToReg,
    output logic [REG_NUM_BITWIDTH-1:0] wb_regToWrite,
    output logic [WORD_BITWIDTH-1:0]    wb_ALUresult,
    output logic [WORD_BITWIDTH-1:0]    wb_readData,
    output logic                        misaligned
);
    localparam int NumBytes = WORD_BITWIDTH / 8;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                      state_q, state_d;
    logic                        req_q, req_d;
    logic                        we_q, we_d;
    logic [WORD_BITWIDTH-1:0]    addr_q, addr_d;
    logic [WORD_BITWIDTH-1:0]    wdata_q, wdata_d;
    logic [3:0]                  be_q, be_d;
    logic                        wbRegWrite_q, wbRegWrite_d;
    logic                        wbMemToReg_q, wbMemToReg_d;
    logic [REG_NUM_BITWIDTH-1:0] wbRegToWrite_q, wbRegToWrite_d;
    logic [WORD_BITWIDTH-1:0]    wbALUresult_q, wbALUresult_d;
    logic [WORD_BITWIDTH-1:0]    wbReadData_q, wbReadData_d;
    logic                        misaligned_q, misaligned_d;

    logic                        access, isByte, isHalf, isWord, misalign;
    logic [1:0]                  addrOff;
    logic [3:0]                  beNew;
    logic [WORD_BITWIDTH-1:0]    wdataNew, loadData;
    logic [7:0]                  byteLane;
    logic [15:0]                 halfLane;

    // Decode access size; codes that are neither byte nor half behave as a word.
    always_comb begin
        access   = mem_memRead | mem_memWrite;
        addrOff  = mem_ALUresult[1:0];
        isByte   = (mem_funct3 == 3'b000) || (mem_funct3 == 3'b100);
        isHalf   = (mem_funct3 == 3'b001) || (mem_funct3 == 3'b101);
        isWord   = ~(isByte | isHalf);
        misalign = access & ((isHalf & addrOff[0]) | (isWord & (addrOff != 2'b00)));
    end

    // Store lanes and load extraction; the EX/MEM inputs stay stable until the ack.
    always_comb begin
        beNew    = 4'b1111;
        wdataNew = mem_finalReadData2;
        if (mem_memWrite && isByte) begin
            beNew    = 4'b0001 << addrOff;
            wdataNew = {NumBytes{mem_finalReadData2[7:0]}};
        end else if (mem_memWrite && isHalf) begin
            beNew    = addrOff[1] ? 4'b1100 : 4'b0011;
            wdataNew = {(NumBytes/2){mem_finalReadData2[15:0]}};
        end
        byteLane = 8'(dmem_rdata >> {addrOff, 3'b000});
        halfLane = 16'(dmem_rdata >> {addrOff[1], 4'b0000});
        if (isByte) begin
            loadData = {{(WORD_BITWIDTH-8){~mem_funct3[2] & byteLane[7]}}, byteLane};
        end else if (isHalf) begin
            loadData = {{(WORD_BITWIDTH-16){~mem_funct3[2] & halfLane[15]}}, halfLane};
        end else begin
            loadData = dmem_rdata;
        end
    end

    // Next-state logic; the MEM/WB register defaults to a bubble whenever we stall.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        wbRegWrite_d   = 1'b0;
        wbMemToReg_d   = 1'b0;
        wbRegToWrite_d = wbRegToWrite_q;
        wbALUresult_d  = wbALUresult_q;
        wbReadData_d   = wbReadData_q;
        misaligned_d   = 1'b0;
        stall          = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !misalign) begin
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = mem_memWrite;
                    addr_d  = {mem_ALUresult[WORD_BITWIDTH-1:2], 2'b00};
                    wdata_d = wdataNew;
                    be_d    = beNew;
                    state_d = WAIT;
                end else begin
                    wbRegWrite_d   = mem_regWrite & ~access;
                    wbMemToReg_d   = mem_memToReg & ~access;
                    wbRegToWrite_d = mem_regToWrite;
                    wbALUresult_d  = mem_ALUresult;
                    wbReadData_d   = '0;
                    misaligned_d   = access;
                end
            end
            WAIT: begin
                stall = ~dmem_ack;
                if (dmem_ack) begin
                    req_d          = 1'b0;
                    state_d        = IDLE;
                    wbRegWrite_d   = mem_regWrite;
                    wbMemToReg_d   = mem_memToReg;
                    wbRegToWrite_d = mem_regToWrite;
                    wbALUresult_d  = mem_ALUresult;
                    wbReadData_d   = we_q ? '0 : loadData;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pipeline registers; reset aborts any outstanding access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            wbRegWrite_q   <= 1'b0;
            wbMemToReg_q   <= 1'b0;
            wbRegToWrite_q <= '0;
            wbALUresult_q  <= '0;
            wbReadData_q   <= '0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            wbRegWrite_q   <= wbRegWrite_d;
            wbMemToReg_q   <= wbMemToReg_d;
            wbRegToWrite_q <= wbRegToWrite_d;
            wbALUresult_q  <= wbALUresult_d;
            wbReadData_q   <= wbReadData_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign dmem_be       = be_q;
    assign wb_regWrite   = wbRegWrite_q;
    assign wb_memToReg   = wbMemToReg_q;
    assign wb_regToWrite = wbRegToWrite_q;
    assign wb_ALUresult  = wbALUresult_q;
    assign wb_readData   = wbReadData_q;
    assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed test-plan scenarios plus randomized
// accesses compared against an arithmetic model of the load/store rules.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_memRead, mem_memWrite, mem_memToReg, mem_regWrite;
    logic [4:0]  mem_regToWrite;
    logic [31:0] mem_ALUresult, mem_finalReadData2;
    logic [2:0]  mem_funct3;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall, wb_regWrite, wb_memToReg, misaligned;
    logic [4:0]  wb_regToWrite;
    logic [31:0] wb_ALUresult, wb_readData;

    int nChecks = 0;
    int nFails  = 0;

    int          oStall, oReq;
    logic        oWe, oHeld, oBubbleOk, oTimeout, oReqAfter;
    logic [31:0] oAddr, oWdata;
    logic [3:0]  oBe;

    typedef struct {
        int          stallCnt;
        int          reqCnt;
        logic        mis;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        regWrite;
        logic        memToReg;
        logic [31:0] readData;
    } expT;

    mem_stage_lsu #(.REG_NUM_BITWIDTH(5), .WORD_BITWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_memToReg(mem_memToReg), .mem_regWrite(mem_regWrite),
        .mem_regToWrite(mem_regToWrite), .mem_ALUresult(mem_ALUresult),
        .mem_finalReadData2(mem_finalReadData2), .mem_funct3(mem_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall(stall),
        .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg),
        .wb_regToWrite(wb_regToWrite), .wb_ALUresult(wb_ALUresult),
        .wb_readData(wb_readData), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    // Access size in bytes decides alignment, lanes and extension width.
    function automatic expT model(input logic r, w, mtr, rw, input logic [31:0] a, d, rdata,
                                  input logic [2:0] f3, input int lat);
        expT e;
        int size, off;
        logic sgn;
        longint unsigned v, lim;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        sgn  = (f3 == 3'd0 || f3 == 3'd1);
        off  = int'(a % 4);
        e.stallCnt = 0; e.reqCnt = 0; e.mis = 0; e.we = 0; e.addr = 0; e.be = 0;
        e.wdata = 0; e.regWrite = rw; e.memToReg = mtr; e.readData = 0;
        if (r || w) begin
            e.mis = (off % size) != 0;
            if (e.mis) begin
                e.regWrite = 0;
                e.memToReg = 0;
            end else begin
                e.stallCnt = lat + 1;
                e.reqCnt   = lat + 1;
                e.we       = w;
                e.addr     = a - 32'(off);
                e.be       = w ? 4'(((1 << size) - 1) << off) : 4'hF;
                lim        = longint'(1) << (8 * size);
                if (size == 4) e.wdata = d;
                else e.wdata = 32'((longint'(d) % lim) * (size == 1 ? 64'h01010101 : 64'h00010001));
                if (!w) begin
                    v = (longint'(rdata) >> (8 * off)) % lim;
                    if (sgn && size < 4 && v >= lim / 2) v = v - lim;
                    e.readData = v[31:0];
                end
            end
        end
        return e;
    endfunction

    task automatic setIdle();
        mem_memRead = 0; mem_memWrite = 0; mem_memToReg = 0; mem_regWrite = 0;
        mem_regToWrite = 0; mem_ALUresult = 0; mem_finalReadData2 = 0; mem_funct3 = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Drives one EX/MEM operation starting at a negedge and plays a memory with 'lat'
    // wait cycles; returns at the negedge after completion with inputs idled.
    task automatic runOp(input logic r, w, mtr, rw, input logic [4:0] rd,
                         input logic [31:0] a, d, input logic [2:0] f3,
                         input int lat, input logic [31:0] rdata);
        int   waited = 0;
        logic done = 0;
        mem_memRead = r; mem_memWrite = w; mem_memToReg = mtr; mem_regWrite = rw;
        mem_regToWrite = rd; mem_ALUresult = a; mem_finalReadData2 = d; mem_funct3 = f3;
        oStall = 0; oReq = 0; oHeld = 1; oBubbleOk = 1; oWe = 0; oAddr = 0; oBe = 0; oWdata = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            dmem_ack = 0;
            if (dmem_req === 1'b1) begin
                if (oReq == 0) begin
                    oWe = dmem_we; oAddr = dmem_addr; oBe = dmem_be; oWdata = dmem_wdata;
                end else if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {oWe, oAddr, oBe, oWdata}) begin
                    oHeld = 0;
                end
                oReq++;
                if (waited == lat) begin
                    dmem_ack = 1; dmem_rdata = rdata;
                end else begin
                    dmem_rdata = $urandom;
                end
                waited++;
            end
            if (c > 0 && (wb_regWrite !== 1'b0 || misaligned !== 1'b0)) oBubbleOk = 0;
            #1;
            if (stall === 1'b1) oStall++;
            else done = 1;
        end
        oTimeout = !done;
        @(negedge clk);
        oReqAfter = dmem_req;
        setIdle();
    endtask

    task automatic test_reset();
        setIdle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== '0) begin
            nFails++; $display("[TB] FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h be=%b, want all 0",
                               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be);
        end
        nChecks++;
        if ({wb_regWrite, wb_memToReg, wb_regToWrite, wb_ALUresult, wb_readData, misaligned} !== '0) begin
            nFails++; $display("[TB] FAIL reset_wb: got rw=%b m2r=%b rd=%0d alu=%h rdata=%h mis=%b, want all 0",
                               wb_regWrite, wb_memToReg, wb_regToWrite, wb_ALUresult, wb_readData, misaligned);
        end
        rst = 0;
    endtask

    task automatic test_load_word();
        runOp(1, 0, 1, 1, 5'd5, 32'h100, 32'h0, 3'b010, 1, 32'hDEADBEEF);
        nChecks++; if (oStall != 2) begin nFails++; $display("[TB] FAIL lw_stall: got %0d want 2", oStall); end
        nChecks++; if (oAddr !== 32'h100 || oBe !== 4'hF || oWe !== 1'b0) begin
            nFails++; $display("[TB] FAIL lw_port: got addr=%h be=%b we=%b want 100/1111/0", oAddr, oBe, oWe); end
        nChecks++; if (wb_readData !== 32'hDEADBEEF) begin
            nFails++; $display("[TB] FAIL lw_data: got %h want deadbeef", wb_readData); end
        nChecks++; if (wb_regWrite !== 1'b1 || wb_regToWrite !== 5'd5) begin
            nFails++; $display("[TB] FAIL lw_ctrl: got rw=%b rd=%0d want 1/5", wb_regWrite, wb_regToWrite); end
        nChecks++; if (oReqAfter !== 1'b0) begin nFails++; $display("[TB] FAIL lw_req_drop: got %b want 0", oReqAfter); end
    endtask

    task automatic test_load_byte();
        runOp(1, 0, 1, 1, 5'd3, 32'h103, 32'h0, 3'b000, 3, 32'h80FF_0000);
        nChecks++; if (oStall != 4) begin nFails++; $display("[TB] FAIL lb_stall: got %0d want 4", oStall); end
        nChecks++; if (oAddr !== 32'h100 || oBe !== 4'hF) begin
            nFails++; $display("[TB] FAIL lb_port: got addr=%h be=%b want 100/1111", oAddr, oBe); end
        nChecks++; if (oHeld !== 1'b1 || oBubbleOk !== 1'b1) begin
            nFails++; $display("[TB] FAIL lb_hold: got held=%b bubble=%b want 1/1", oHeld, oBubbleOk); end
        nChecks++; if (wb_readData !== 32'hFFFFFF80) begin
            nFails++; $display("[TB] FAIL lb_data: got %h want ffffff80", wb_readData); end
        runOp(1, 0, 1, 1, 5'd3, 32'h103, 32'h0, 3'b100, 3, 32'h80FF_0000);
        nChecks++; if (wb_readData !== 32'h00000080) begin
            nFails++; $display("[TB] FAIL lbu_data: got %h want 00000080", wb_readData); end
    endtask

    task automatic test_store_byte();
        runOp(0, 1, 0, 0, 5'd0, 32'h102, 32'h0000_00A5, 3'b000, 2, 32'h1234_5678);
        nChecks++; if (oWe !== 1'b1 || oBe !== 4'b0100 || oWdata !== 32'hA5A5A5A5) begin
            nFails++; $display("[TB] FAIL sb_port: got we=%b be=%b wdata=%h want 1/0100/a5a5a5a5", oWe, oBe, oWdata); end
        nChecks++; if (wb_regWrite !== 1'b0 || misaligned !== 1'b0 || wb_readData !== 32'h0) begin
            nFails++; $display("[TB] FAIL sb_wb: got rw=%b mis=%b rdata=%h want 0/0/0", wb_regWrite, misaligned, wb_readData); end
    endtask

    task automatic test_misaligned();
        runOp(1, 0, 1, 1, 5'd4, 32'h101, 32'h0, 3'b001, 0, 32'h0);
        nChecks++; if (oStall != 0 || oReq != 0 || oReqAfter !== 1'b0) begin
            nFails++; $display("[TB] FAIL lh_mis_noreq: got stall=%0d req=%0d reqAfter=%b want 0/0/0", oStall, oReq, oReqAfter); end
        nChecks++; if (misaligned !== 1'b1 || wb_regWrite !== 1'b0) begin
            nFails++; $display("[TB] FAIL lh_mis_flag: got mis=%b rw=%b want 1/0", misaligned, wb_regWrite); end
        runOp(0, 1, 0, 1, 5'd4, 32'h102, 32'hFFFF_FFFF, 3'b010, 0, 32'h0);
        nChecks++; if (misaligned !== 1'b1 || wb_regWrite !== 1'b0 || oReq != 0 || oReqAfter !== 1'b0) begin
            nFails++; $display("[TB] FAIL sw_mis: got mis=%b rw=%b req=%0d/%b want 1/0/0/0", misaligned, wb_regWrite, oReq, oReqAfter); end
        @(negedge clk);
        nChecks++; if (misaligned !== 1'b0) begin nFails++; $display("[TB] FAIL mis_pulse: got %b want 0", misaligned); end
    endtask

    task automatic test_alu_passthrough();
        runOp(0, 0, 0, 1, 5'd7, 32'd42, 32'h0, 3'b010, 0, 32'h0);
        nChecks++; if (oStall != 0) begin nFails++; $display("[TB] FAIL alu_stall: got %0d want 0", oStall); end
        nChecks++; if (wb_regWrite !== 1'b1 || wb_regToWrite !== 5'd7 || wb_ALUresult !== 32'd42 || wb_readData !== 32'h0) begin
            nFails++; $display("[TB] FAIL alu_wb: got rw=%b rd=%0d alu=%0d rdata=%h want 1/7/42/0",
                               wb_regWrite, wb_regToWrite, wb_ALUresult, wb_readData); end
    endtask

    task automatic test_back_to_back();
        runOp(1, 0, 1, 1, 5'd1, 32'h40, 32'h0, 3'b010, 0, 32'h1111_2222);
        nChecks++; if (wb_readData !== 32'h1111_2222 || oStall != 1) begin
            nFails++; $display("[TB] FAIL b2b_first: got rdata=%h stall=%0d want 11112222/1", wb_readData, oStall); end
        runOp(1, 0, 1, 1, 5'd2, 32'h42, 32'h0, 3'b001, 0, 32'h8001_1234);
        nChecks++; if (oReq != 1 || oStall != 1) begin
            nFails++; $display("[TB] FAIL b2b_issue: got req=%0d stall=%0d want 1/1", oReq, oStall); end
        nChecks++; if (wb_readData !== 32'hFFFF8001 || wb_regToWrite !== 5'd2) begin
            nFails++; $display("[TB] FAIL b2b_second: got rdata=%h rd=%0d want ffff8001/2", wb_readData, wb_regToWrite); end
    endtask

    task automatic test_random();
        logic [2:0] codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 60; i++) begin
            logic        r, w, mtr, rw;
            logic [4:0]  rd;
            logic [31:0] a, d, rdata;
            logic [2:0]  f3;
            int          lat, sel;
            expT         e;
            sel = $urandom_range(0, 3);
            r = sel[0]; w = sel[1];
            mtr = 1'($urandom); rw = 1'($urandom); rd = 5'($urandom);
            a = $urandom; d = $urandom; rdata = $urandom;
            f3 = codes[$urandom_range(0, 7)];
            lat = $urandom_range(0, 3);
            e = model(r, w, mtr, rw, a, d, rdata, f3, lat);
            runOp(r, w, mtr, rw, rd, a, d, f3, lat, rdata);
            nChecks++; if (oTimeout !== 1'b0 || oStall != e.stallCnt || oReq != e.reqCnt || oReqAfter !== 1'b0) begin
                nFails++; $display("[TB] FAIL rnd_timing[%0d]: got stall=%0d req=%0d to=%b reqAfter=%b want %0d/%0d/0/0",
                                   i, oStall, oReq, oTimeout, oReqAfter, e.stallCnt, e.reqCnt); end
            nChecks++; if (misaligned !== e.mis || wb_regWrite !== e.regWrite || wb_memToReg !== e.memToReg) begin
                nFails++; $display("[TB] FAIL rnd_ctrl[%0d]: got mis=%b rw=%b m2r=%b want %b/%b/%b",
                                   i, misaligned, wb_regWrite, wb_memToReg, e.mis, e.regWrite, e.memToReg); end
            if (!e.mis) begin
                nChecks++; if (wb_readData !== e.readData || wb_ALUresult !== a || wb_regToWrite !== rd) begin
                    nFails++; $display("[TB] FAIL rnd_wb[%0d]: got rdata=%h alu=%h rd=%0d want %h/%h/%0d",
                                       i, wb_readData, wb_ALUresult, wb_regToWrite, e.readData, a, rd); end
            end
            if (e.reqCnt > 0) begin
                nChecks++; if (oWe !== e.we || oAddr !== e.addr || oBe !== e.be || (e.we && oWdata !== e.wdata)
                               || oHeld !== 1'b1 || oBubbleOk !== 1'b1) begin
                    nFails++; $display("[TB] FAIL rnd_port[%0d]: got we=%b addr=%h be=%b wdata=%h held=%b bub=%b want %b/%h/%b/%h/1/1",
                                       i, oWe, oAddr, oBe, oWdata, oHeld, oBubbleOk, e.we, e.addr, e.be, e.wdata); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        mem_memRead = 1; mem_memToReg = 1; mem_regWrite = 1; mem_regToWrite = 5'd9;
        mem_ALUresult = 32'h200; mem_funct3 = 3'b010; dmem_ack = 0;
        repeat (3) @(negedge clk);
        nChecks++; if (dmem_req !== 1'b1) begin nFails++; $display("[TB] FAIL rst_pre_req: got %b want 1", dmem_req); end
        #1 rst = 1;
        setIdle();
        #1;
        nChecks++; if ({dmem_req, dmem_addr, dmem_be, wb_regWrite, wb_regToWrite, wb_ALUresult, wb_readData, misaligned} !== '0) begin
            nFails++; $display("[TB] FAIL rst_abort: got req=%b addr=%h be=%b rw=%b rd=%0d alu=%h rdata=%h mis=%b want all 0",
                               dmem_req, dmem_addr, dmem_be, wb_regWrite, wb_regToWrite, wb_ALUresult, wb_readData, misaligned); end
        @(negedge clk);
        rst = 0;
        mem_memToReg = 1; dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_ack = 0; mem_memToReg = 0;
        nChecks++; if (wb_readData !== 32'h0 || wb_regWrite !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0) begin
            nFails++; $display("[TB] FAIL rst_stray_ack: got rdata=%h rw=%b req=%b stall=%b want 0/0/0/0",
                               wb_readData, wb_regWrite, dmem_req, stall); end
        runOp(1, 0, 1, 1, 5'd6, 32'h300, 32'h0, 3'b010, 0, 32'h0BAD_F00D);
        nChecks++; if (wb_readData !== 32'h0BAD_F00D || oStall != 1) begin
            nFails++; $display("[TB] FAIL rst_recover: got rdata=%h stall=%0d want 0badf00d/1", wb_readData, oStall); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_byte();
        test_misaligned();
        test_alu_passthrough();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
